reg_file_param: RTL and testbench
=================================

Name: reg_file_param

Overview:
Parametrised register file, next generation of the system's 8x16 config/data register bank. Serves single-cycle bus writes and reads with 1- or 2-cycle read latency and defined simultaneous read/write behaviour. Flags out-of-range addresses and exports the low NUM_EXPORT entries as configuration outputs (ALU operands, UART/clock-divider config).

Parameters:
DATA_W, 8, data width in bits
ADDR_W, 4, address width
DEPTH, 16, implemented entries (2 <= DEPTH <= 2**ADDR_W, DEPTH >= NUM_EXPORT)
NUM_EXPORT, 4, entries 0..NUM_EXPORT-1 driven continuously on REG_OUT
RD_LAT, 1, read latency in cycles (1 or 2; other values are an elaboration error)
EXPORT_RST, {8'h20,8'h81,8'h00,8'h00}, packed reset values for exported entries (entry 0 in LSBs); all other entries reset to 0

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
WrEn  in  1  write strobe
RdEn  in  1  read strobe
Address  in  ADDR_W  entry index for this cycle
WrData  in  DATA_W  write data
RdData  out  DATA_W  read data, valid while RdData_Valid=1
RdData_Valid  out  1  one-cycle pulse per accepted read
Addr_Err  out  1  pulse aligned with RdData_Valid, or one cycle after a write, when Address >= DEPTH
REG_OUT  out  NUM_EXPORT*DATA_W  flattened entries 0..NUM_EXPORT-1, entry 0 in LSBs
Par_Err  out  1  parity error pulse (see Optional Feature)

Behaviour:
- Reset, asynchronous and active-high, while RST=1: entries get EXPORT_RST/0; RdData=0, RdData_Valid=0, Addr_Err=0, Par_Err=0; read pipeline flushed. Reset mid-read discards the in-flight read; no Valid follows deassertion.
- Write: WrEn=1 at edge, Address<DEPTH -> entry updated at that edge; REG_OUT reflects it the next cycle.
- Read: RdEn=1 at edge k -> RdData/RdData_Valid presented after edge k+RD_LAT-1 (RD_LAT=1: the same edge, i.e. visible in cycle k+1). Back-to-back reads are accepted every cycle. With RD_LAT=2 the pipeline stays fully throughput-capable.
- WrEn=1 and RdEn=1 same cycle: both performed. Same address -> RdData=WrData (write-through bypass). Both go to the same Address because the bus is single-port.
- No RdEn: RdData holds its last value; RdData_Valid=0.
- Address >= DEPTH: write dropped; read returns RdData=0 with RdData_Valid=1 and Addr_Err=1; an erroneous write pulses Addr_Err the cycle after, with RdData_Valid=0.
- Address wrap: no wrap, because out-of-range accesses are errors and never alias.
- Widths: all storage is DATA_W; no arithmetic.

Optional Feature:
Macro REGFILE_PARITY_EN.
- Defined: each entry stores an even-parity bit computed from WrData. Input Par_Inj (1 bit, added only under the macro) inverts the stored parity bit for the write in that cycle. A read checks parity and raises Par_Err aligned with RdData_Valid; data is still returned. Bypass reads check WrData parity with Par_Inj applied.
- Undefined: no parity storage, no Par_Inj port, Par_Err tied to 0.

Decomposition:
- Package reg_file_pkg: localparams RD_LAT_MAX=2 and the default EXPORT_RST vector; a function for even parity over DATA_W.
- Sub-module reg_file_rd_pipe: a 0/1 extra stage delay line for {RdData, RdData_Valid, Addr_Err, Par_Err}, instantiated when RD_LAT=2.

Test Plan:
1. Assert RST mid-cycle, then release -> REG_OUT = 0x20_81_00_00, all other reads return 0x00, no spurious RdData_Valid.
2. Write 0x5A to addr 7, then read addr 7 -> RdData=0x5A, Valid pulse one cycle wide; with RD_LAT=2 it arrives one cycle later, and back-to-back reads of 7 and 2 yield 0x5A then 0x81 on consecutive cycles.
3. WrEn+RdEn together at addr 3 with WrData 0xC3 -> RdData=0xC3 and REG_OUT[31:24]=0xC3 on the next cycle.
4. With DEPTH=12, write 0xFF to addr 13 then read addr 13 -> write dropped (all entries unchanged), read gives RdData=0, Valid=1, Addr_Err=1; the write cycle pulses Addr_Err.
5. With RD_LAT=2, issue a read of addr 2 and assert RST on the next edge -> no Valid after release, RdData=0.
6. With REGFILE_PARITY_EN: write 0x81 with Par_Inj=1 to addr 5, then read -> RdData=0x81, Par_Err=1; rewrite with Par_Inj=0 -> Par_Err=0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the parametrised register file.
// Parity support is enabled by defining REGFILE_PARITY_EN.
package reg_file_pkg;

    localparam int RD_LAT_MAX = 2;

    // Entry 3 = 0x20, entry 2 = 0x81, entries 1/0 = 0x00 (entry 0 in LSBs)
    localparam logic [31:0] EXPORT_RST_DEFAULT = {8'h20, 8'h81, 8'h00, 8'h00};

    localparam int PAR_W_MAX = 64;

    // Even-parity bit: makes the total count of ones (data + bit) even.
    function automatic logic even_parity(input logic [PAR_W_MAX-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/reg_file_rd_pipe.sv
// One extra register stage for the read response, used when RD_LAT=2.
module reg_file_rd_pipe #(
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] data_i,
    input  logic              vld_i,
    input  logic              aerr_i,
    input  logic              perr_i,
    output logic [DATA_W-1:0] data_o,
    output logic              vld_o,
    output logic              aerr_o,
    output logic              perr_o
);

    logic [DATA_W-1:0] data_q;
    logic              vld_q;
    logic              aerr_q;
    logic              perr_q;

    // The upstream stage already holds its data between reads, so copying every cycle keeps RdData stable.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data_q <= '0;
            vld_q  <= 1'b0;
            aerr_q <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            data_q <= data_i;
            vld_q  <= vld_i;
            aerr_q <= aerr_i;
            perr_q <= perr_i;
        end
    end

    assign data_o = data_q;
    assign vld_o  = vld_q;
    assign aerr_o = aerr_q;
    assign perr_o = perr_q;

endmodule

// File: rtl/reg_file_param.sv
// Parametrised register file with 1/2-cycle reads, write-through bypass and range checking.
// Optional per-entry parity (Par_Inj input, Par_Err output) when REGFILE_PARITY_EN is defined.
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 4,
    parameter int DEPTH      = 16,
    parameter int NUM_EXPORT = 4,
    parameter int RD_LAT     = 1,
    parameter logic [NUM_EXPORT*DATA_W-1:0] EXPORT_RST = (NUM_EXPORT*DATA_W)'(EXPORT_RST_DEFAULT)
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         WrEn,
    input  logic                         RdEn,
    input  logic [ADDR_W-1:0]            Address,
    input  logic [DATA_W-1:0]            WrData,
`ifdef REGFILE_PARITY_EN
    input  logic                         Par_Inj,
`endif
    output logic [DATA_W-1:0]            RdData,
    output logic                         RdData_Valid,
    output logic                         Addr_Err,
    output logic [NUM_EXPORT*DATA_W-1:0] REG_OUT,
    output logic                         Par_Err
);

    generate
        if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
            $error("reg_file_param: RD_LAT must be 1 or 2");
        end
        if (DEPTH < 2 || DEPTH > (1 << ADDR_W) || DEPTH < NUM_EXPORT) begin : g_bad_depth
            $error("reg_file_param: DEPTH out of range");
        end
        if (DATA_W > PAR_W_MAX) begin : g_bad_width
            $error("reg_file_param: DATA_W too wide for parity helper");
        end
    endgenerate

    function automatic logic [DATA_W-1:0] rst_val(input int idx);
        rst_val = '0;
        for (int i = 0; i < NUM_EXPORT; i++) begin
            if (i == idx) rst_val = EXPORT_RST[i*DATA_W +: DATA_W];
        end
    endfunction

    logic              addr_ok;
    logic [DATA_W-1:0] mem_w [DEPTH];
    logic [DATA_W-1:0] rd_word;
`ifdef REGFILE_PARITY_EN
    logic              par_w [DEPTH];
    logic              rd_par;
    logic              wr_par;
`endif

    // Out-of-range addresses never alias onto an implemented entry.
    assign addr_ok = ({1'b0, Address} < (ADDR_W+1)'(DEPTH));

`ifdef REGFILE_PARITY_EN
    assign wr_par = even_parity(PAR_W_MAX'(WrData)) ^ Par_Inj;
`endif

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_entry
            logic [DATA_W-1:0] data_q;
            logic              wr_hit;

            assign wr_hit   = WrEn && (Address == ADDR_W'(g));
            assign mem_w[g] = data_q;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST)         data_q <= rst_val(g);
                else if (wr_hit) data_q <= WrData;
            end

`ifdef REGFILE_PARITY_EN
            logic par_q;
            assign par_w[g] = par_q;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST)         par_q <= even_parity(PAR_W_MAX'(rst_val(g)));
                else if (wr_hit) par_q <= wr_par;
            end
`endif
        end

        for (g = 0; g < NUM_EXPORT; g++) begin : g_export
            assign REG_OUT[g*DATA_W +: DATA_W] = mem_w[g];
        end
    endgenerate

    always_comb begin
        rd_word = '0;
`ifdef REGFILE_PARITY_EN
        rd_par  = 1'b0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            if (Address == ADDR_W'(i)) begin
                rd_word = mem_w[i];
`ifdef REGFILE_PARITY_EN
                rd_par  = par_w[i];
`endif
            end
        end
    end

    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_vld_q, rd_vld_d;
    logic              rd_aerr_q, rd_aerr_d;
    logic              rd_perr_q, rd_perr_d;
    logic              wr_aerr_q, wr_aerr_d;

    always_comb begin
        rd_vld_d  = RdEn;
        rd_aerr_d = RdEn && !addr_ok;
        wr_aerr_d = WrEn && !RdEn && !addr_ok;
        rd_data_d = rd_data_q;
        rd_perr_d = 1'b0;
        if (RdEn) begin
            if (!addr_ok)  rd_data_d = '0;
            else if (WrEn) rd_data_d = WrData;
            else           rd_data_d = rd_word;
        end
`ifdef REGFILE_PARITY_EN
        // A bypassed read sees exactly the parity the write is about to store.
        if (RdEn && addr_ok) begin
            if (WrEn) rd_perr_d = Par_Inj;
            else      rd_perr_d = (rd_par != even_parity(PAR_W_MAX'(rd_word)));
        end
`endif
    end

    // Read response stage: registered at the edge that accepts the read
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_data_q <= '0;
            rd_vld_q  <= 1'b0;
            rd_aerr_q <= 1'b0;
            rd_perr_q <= 1'b0;
            wr_aerr_q <= 1'b0;
        end else begin
            rd_data_q <= rd_data_d;
            rd_vld_q  <= rd_vld_d;
            rd_aerr_q <= rd_aerr_d;
            rd_perr_q <= rd_perr_d;
            wr_aerr_q <= wr_aerr_d;
        end
    end

    logic rd_aerr_out;

    generate
        if (RD_LAT == 2) begin : g_lat2
            reg_file_rd_pipe #(
                .DATA_W (DATA_W)
            ) u_rd_pipe (
                .CLK    (CLK),
                .RST    (RST),
                .data_i (rd_data_q),
                .vld_i  (rd_vld_q),
                .aerr_i (rd_aerr_q),
                .perr_i (rd_perr_q),
                .data_o (RdData),
                .vld_o  (RdData_Valid),
                .aerr_o (rd_aerr_out),
                .perr_o (Par_Err)
            );
        end else begin : g_lat1
            assign RdData       = rd_data_q;
            assign RdData_Valid = rd_vld_q;
            assign rd_aerr_out  = rd_aerr_q;
            assign Par_Err      = rd_perr_q;
        end
    endgenerate

    // Write errors report the cycle after the write regardless of read latency.
    assign Addr_Err = rd_aerr_out | wr_aerr_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param: a default instance (DEPTH=16, RD_LAT=1)
// and a DEPTH=12, RD_LAT=2 instance driven with directed vectors.
module tb_reg_file_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         due;
        bit         rd;
        logic [7:0] data;
        bit         aerr;
        bit         perr;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 1'b0;

    logic        rst0 = 1'b0, we0 = 1'b0, re0 = 1'b0, inj0 = 1'b0;
    logic [3:0]  a0 = '0;
    logic [7:0]  wd0 = '0;
    logic [7:0]  rd0;
    logic        v0, ae0, pe0;
    logic [31:0] regout0;

    logic        rst1 = 1'b0, we1 = 1'b0, re1 = 1'b0, inj1 = 1'b0;
    logic [3:0]  a1 = '0;
    logic [7:0]  wd1 = '0;
    logic [7:0]  rd1;
    logic        v1, ae1, pe1;
    logic [31:0] regout1;

    reg_file_param u_dut0 (
        .CLK          (clk),
        .RST          (rst0),
        .WrEn         (we0),
        .RdEn         (re0),
        .Address      (a0),
        .WrData       (wd0),
`ifdef REGFILE_PARITY_EN
        .Par_Inj      (inj0),
`endif
        .RdData       (rd0),
        .RdData_Valid (v0),
        .Addr_Err     (ae0),
        .REG_OUT      (regout0),
        .Par_Err      (pe0)
    );

    reg_file_param #(
        .DEPTH  (12),
        .RD_LAT (2)
    ) u_dut1 (
        .CLK          (clk),
        .RST          (rst1),
        .WrEn         (we1),
        .RdEn         (re1),
        .Address      (a1),
        .WrData       (wd1),
`ifdef REGFILE_PARITY_EN
        .Par_Inj      (inj1),
`endif
        .RdData       (rd1),
        .RdData_Valid (v1),
        .Addr_Err     (ae1),
        .REG_OUT      (regout1),
        .Par_Err      (pe1)
    );

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d @cyc %0d: got %h, expected %h", name, d, cyc, act, exp);
        end
    endtask

    // Drive one bus cycle; the expected response is queued with the cycle it is due.
    task automatic op(input int d, input bit we, input bit re, input bit inj, input logic [3:0] a,
                      input logic [7:0] wd, input logic [7:0] ed, input bit eae, input bit epe);
        exp_t e;
        int   depth;
        int   lat;
        depth = (d == 0) ? 16 : 12;
        lat   = (d == 0) ? 1 : 2;
        if (d == 0) begin
            we0 = we; re0 = re; inj0 = inj; a0 = a; wd0 = wd;
        end else begin
            we1 = we; re1 = re; inj1 = inj; a1 = a; wd1 = wd;
        end
        if (re) begin
            e = '{cyc + lat, 1'b1, ed, eae, epe};
            if (d == 0) q0.push_back(e); else q1.push_back(e);
        end else if (we && int'(a) >= depth) begin
            e = '{cyc + 1, 1'b0, 8'h00, 1'b1, 1'b0};
            if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        we0 = 1'b0; re0 = 1'b0; inj0 = 1'b0;
        we1 = 1'b0; re1 = 1'b0; inj1 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mon(input int d, input logic v, input logic ae, input logic pe, input logic [7:0] rd);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (d == 0) begin
            if (q0.size() > 0 && q0[0].due == cyc) begin e = q0.pop_front(); have = 1'b1; end
        end else begin
            if (q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); have = 1'b1; end
        end
        if (have) begin
            chk("valid", d, 32'(v), 32'(e.rd));
            chk("addr_err", d, 32'(ae), 32'(e.aerr));
            if (e.rd) begin
                chk("rddata", d, 32'(rd), 32'(e.data));
                chk("par_err", d, 32'(pe), 32'(e.perr));
            end
        end else begin
            chk("idle_valid", d, 32'(v), 32'd0);
            chk("idle_addr_err", d, 32'(ae), 32'd0);
            chk("idle_par_err", d, 32'(pe), 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            mon(0, v0, ae0, pe0, rd0);
            mon(1, v1, ae1, pe1, rd1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] rst_entry(input int a);
        if (a == 2) return 8'h81;
        if (a == 3) return 8'h20;
        return 8'h00;
    endfunction

    initial begin
        logic [7:0] e1;

        // Reset asserted mid-cycle, outputs checked while it is held.
        #13;
        rst0 = 1'b1; rst1 = 1'b1;
        #4;
        chk("rst_regout", 0, regout0, 32'h2081_0000);
        chk("rst_regout", 1, regout1, 32'h2081_0000);
        chk("rst_rddata", 0, 32'(rd0), 32'd0);
        chk("rst_valid", 1, 32'(v1), 32'd0);
        chk("rst_addr_err", 0, 32'(ae0), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst0 = 1'b0; rst1 = 1'b0;
        started = 1'b1;
        idle(2);
        chk("post_rst_regout", 0, regout0, 32'h2081_0000);

        for (int a = 0; a < 16; a++) op(0, 0, 1, 0, 4'(a), 8'h00, rst_entry(a), 0, 0);
        op(0, 0, 1, 0, 4'd2, 8'h00, 8'h81, 0, 0);
        idle(3);
        chk("rddata_hold", 0, 32'(rd0), 32'h81);

        // Write then read, both latencies; back-to-back reads on the RD_LAT=2 instance.
        op(0, 1, 0, 0, 4'd7, 8'h5A, 8'h00, 0, 0);
        op(0, 0, 1, 0, 4'd7, 8'h00, 8'h5A, 0, 0);
        op(1, 1, 0, 0, 4'd7, 8'h5A, 8'h00, 0, 0);
        op(1, 0, 1, 0, 4'd7, 8'h00, 8'h5A, 0, 0);
        op(1, 0, 1, 0, 4'd2, 8'h00, 8'h81, 0, 0);
        idle(3);
        chk("rddata_hold", 1, 32'(rd1), 32'h81);

        // Simultaneous write and read of an exported entry.
        op(0, 1, 1, 0, 4'd3, 8'hC3, 8'hC3, 0, 0);
        chk("regout_byte3", 0, 32'(regout0[31:24]), 32'hC3);
        chk("regout_low", 0, 32'(regout0[23:0]), 32'h81_0000);
        op(0, 0, 1, 0, 4'd3, 8'h00, 8'hC3, 0, 0);

        // Top implemented address of the full-depth instance.
        op(0, 1, 0, 0, 4'd15, 8'hEE, 8'h00, 0, 0);
        op(0, 0, 1, 0, 4'd15, 8'h00, 8'hEE, 0, 0);
        idle(2);

        // Out-of-range accesses on the DEPTH=12 instance.
        op(1, 1, 0, 0, 4'd13, 8'hFF, 8'h00, 0, 0);
        op(1, 0, 1, 0, 4'd13, 8'h00, 8'h00, 1, 0);
        idle(2);
        op(1, 1, 0, 0, 4'd11, 8'h3C, 8'h00, 0, 0);
        for (int a = 0; a < 12; a++) begin
            e1 = rst_entry(a);
            if (a == 7)  e1 = 8'h5A;
            if (a == 11) e1 = 8'h3C;
            op(1, 0, 1, 0, 4'(a), 8'h00, e1, 0, 0);
        end
        op(1, 0, 1, 0, 4'd12, 8'h00, 8'h00, 1, 0);
        idle(3);
        chk("err_rddata_zero", 1, 32'(rd1), 32'h00);
        chk("regout_unchanged", 1, regout1, 32'h2081_0000);

        // Reset lands while a 2-cycle read is in flight.
        idle(2);
        re1 = 1'b1; a1 = 4'd2;
        @(posedge clk);
        #1;
        rst1 = 1'b1; re1 = 1'b0;
        #1;
        chk("flush_valid", 1, 32'(v1), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst1 = 1'b0;
        idle(1);
        chk("flush_rddata", 1, 32'(rd1), 32'd0);
        idle(3);
        op(1, 0, 1, 0, 4'd7, 8'h00, 8'h00, 0, 0);
        op(1, 0, 1, 0, 4'd2, 8'h00, 8'h81, 0, 0);
        idle(3);

`ifdef REGFILE_PARITY_EN
        op(0, 1, 0, 1, 4'd5, 8'h81, 8'h00, 0, 0);
        op(0, 0, 1, 0, 4'd5, 8'h00, 8'h81, 0, 1);
        op(0, 1, 0, 0, 4'd5, 8'h81, 8'h00, 0, 0);
        op(0, 0, 1, 0, 4'd5, 8'h00, 8'h81, 0, 0);
        op(0, 1, 1, 1, 4'd6, 8'h01, 8'h01, 0, 1);
        op(0, 0, 1, 0, 4'd6, 8'h00, 8'h01, 0, 1);
        op(0, 0, 1, 0, 4'd3, 8'h00, 8'hC3, 0, 0);
        idle(3);
`endif

        idle(4);
        chk("q_drained", 0, 32'(q0.size()), 32'd0);
        chk("q_drained", 1, 32'(q1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
